product_accumulator: RTL and testbench

Downstream consumer of the sequential shift-add multiplier. It captures each completed product, sums a fixed number (LEN) of consecutive products into a widened accumulator, and presents the sum through a valid/ack handshake. This forms the accumulate half of a dot-product datapath. It decouples the multiplier from the result consumer with a one-entry pending slot.

---
 rtl/mult_pkg.sv | 27 ++
 rtl/rise_detect.sv | 32 +++
 rtl/product_accumulator.sv | 159 +++++++++++++++
 tb/tb_product_accumulator.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier and the blocks downstream of it.
package mult_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } acc_state_e;

  // Ceiling log2 that is usable in parameter expressions.
  function automatic int unsigned clog2_u(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Width of a sum of len products of two n-bit operands, sized so it cannot wrap.
  function automatic int unsigned acc_width(input int unsigned n, input int unsigned len);
    return (2 * n) + clog2_u(len + 1);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Registers a level and flags its rising edge; stays disarmed after reset until the level has been seen low.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic level_q,
  output logic pulse_c
);

  logic level_d;
  logic armed_q;
  logic armed_d;

  // A level already high when reset releases must fall before it can count.
  always_comb begin
    level_d = level;
    armed_d = armed_q | ~level;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      level_q <= level_d;
      armed_q <= armed_d;
    end
  end

  assign pulse_c = level & ~level_q & armed_q;

endmodule

// File: rtl/product_accumulator.sv
// Sums LEN consecutive multiplier products and hands the sum out over a valid/ack handshake,
// with a one-entry slot absorbing a product that arrives while a result is still unacknowledged.
module product_accumulator
  import mult_pkg::*;
#(
  parameter  int unsigned N     = 4,
  parameter  int unsigned LEN   = 4,
  localparam int unsigned ACC_W = acc_width(N, LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             prod_ready,
  input  logic [2*N-1:0]   product,
  output logic [ACC_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ack,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned PROD_W = 2 * N;
  localparam int unsigned CNT_W  = clog2_u(LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  acc_state_e        state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PROD_W-1:0] pend_data_q, pend_data_d;
  logic              pend_full_q, pend_full_d;
  logic [ACC_W-1:0]  result_q, result_d;
  logic              result_valid_q, result_valid_d;
  logic              overrun_q, overrun_d;
  logic              busy_q, busy_d;

  logic              rise_c;
  logic              unused_ready_d;
  logic              cap_c;
  logic [ACC_W-1:0]  prod_ext_c;
  logic [ACC_W-1:0]  pend_ext_c;
  logic [ACC_W-1:0]  add_val_c;

  rise_detect u_rise (
    .clk     (clk),
    .rst_n   (rst_n),
    .level   (prod_ready),
    .level_q (unused_ready_d),
    .pulse_c (rise_c)
  );

  assign cap_c      = rise_c & ~clear;
  assign prod_ext_c = ACC_W'(product);
  assign pend_ext_c = ACC_W'(pend_data_q);
  // In ACCUM a parked product takes precedence over the live input.
  assign add_val_c  = pend_full_q ? pend_ext_c : prod_ext_c;

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    pend_data_d    = pend_data_q;
    pend_full_d    = pend_full_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    overrun_d      = overrun_q;

    if (clear) begin
      state_d        = ACCUM;
      acc_d          = '0;
      cnt_d          = '0;
      pend_full_d    = 1'b0;
      result_valid_d = 1'b0;
      overrun_d      = 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (cap_c || pend_full_q) begin
            if (pend_full_q) begin
              // Draining the slot; a simultaneous capture simply re-parks.
              pend_full_d = cap_c;
              if (cap_c) begin
                pend_data_d = product;
              end
            end
            if (cnt_q == CNT_LAST) begin
              result_d       = acc_q + add_val_c;
              result_valid_d = 1'b1;
              acc_d          = '0;
              cnt_d          = '0;
              state_d        = DONE;
            end else begin
              acc_d = acc_q + add_val_c;
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        DONE: begin
          if (result_ack) begin
            result_valid_d = 1'b0;
            state_d        = ACCUM;
            if (pend_full_q) begin
              acc_d = pend_ext_c;
              cnt_d = CNT_ONE;
              if (cap_c) begin
                pend_data_d = product;
              end else begin
                pend_full_d = 1'b0;
              end
            end else if (cap_c) begin
              acc_d = prod_ext_c;
              cnt_d = CNT_ONE;
            end
          end else if (cap_c) begin
            if (!pend_full_q) begin
              pend_data_d = product;
              pend_full_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
        default: state_d = ACCUM;
      endcase
    end

    busy_d = (cnt_d != '0) || pend_full_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ACCUM;
      acc_q          <= '0;
      cnt_q          <= '0;
      pend_data_q    <= '0;
      pend_full_q    <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      pend_data_q    <= pend_data_d;
      pend_full_q    <= pend_full_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      overrun_q      <= overrun_d;
      busy_q         <= busy_d;
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign overrun      = overrun_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: expected sums go into a queue, a monitor checks each presented result.
module tb_product_accumulator;
  import mult_pkg::*;

  localparam int unsigned N     = 4;
  localparam int unsigned LEN   = 4;
  localparam int unsigned ACC_W = acc_width(N, LEN);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear;
  logic             prod_ready;
  logic [2*N-1:0]   product;
  logic [ACC_W-1:0] result;
  logic             result_valid;
  logic             result_ack;
  logic             busy;
  logic             overrun;

  int          n_checks = 0;
  int          n_pass   = 0;
  int unsigned exp_q[$];
  logic        rv_prev  = 1'b0;

  always #5 clk = ~clk;

  product_accumulator #(.N(N), .LEN(LEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .prod_ready   (prod_ready),
    .product      (product),
    .result       (result),
    .result_valid (result_valid),
    .result_ack   (result_ack),
    .busy         (busy),
    .overrun      (overrun)
  );

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: each new result presentation is compared against the oldest expectation.
  always @(negedge clk) begin
    if (result_valid && !rv_prev) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected: got result %0d expected no result", result);
      end else begin
        check("sb_result", 32'(result), exp_q.pop_front());
      end
    end
    rv_prev = result_valid;
  end

  // One-cycle prod_ready pulse; returns at the negedge just after the capture edge.
  task automatic send(input int unsigned v);
    @(negedge clk);
    product    = 8'(v);
    prod_ready = 1'b1;
    @(negedge clk);
    prod_ready = 1'b0;
  endtask

  task automatic do_ack();
    int unsigned k;
    k = 0;
    while (!result_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("ack_wait_rv", 32'(result_valid), 1);
    if (result_valid) begin
      result_ack = 1'b1;
      @(negedge clk);
      result_ack = 1'b0;
      check("rv_after_ack", 32'(result_valid), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    clear      = 1'b0;
    prod_ready = 1'b0;
    result_ack = 1'b0;
    product    = '0;
    repeat (2) @(negedge clk);
    check("rst_result", 32'(result), 0);
    check("rst_rv", 32'(result_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overrun", 32'(overrun), 0);
    rst_n = 1'b1;

    // Basic set 3+5+7+9
    exp_q.push_back(24);
    send(3); send(5); send(7);
    check("basic_busy", 32'(busy), 1);
    check("basic_rv_early", 32'(result_valid), 0);
    send(9);
    check("basic_latency_rv", 32'(result_valid), 1);
    repeat (3) @(negedge clk);
    check("basic_held_rv", 32'(result_valid), 1);
    check("basic_held_result", 32'(result), 24);
    do_ack();
    check("basic_idle_busy", 32'(busy), 0);

    // Level held high counts once
    @(negedge clk);
    product    = 8'd11;
    prod_ready = 1'b1;
    repeat (6) @(negedge clk);
    prod_ready = 1'b0;
    check("level_cnt", 32'(dut.cnt_q), 1);
    check("level_acc", 32'(dut.acc_q), 11);
    exp_q.push_back(44);
    send(11); send(11); send(11);
    do_ack();

    // Max values, then ack coincident with a fresh capture
    exp_q.push_back(900);
    send(225); send(225); send(225); send(225);
    @(negedge clk);
    result_ack = 1'b1;
    product    = 8'd5;
    prod_ready = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    prod_ready = 1'b0;
    check("ackcap_rv", 32'(result_valid), 0);
    check("ackcap_cnt", 32'(dut.cnt_q), 1);
    check("ackcap_acc", 32'(dut.acc_q), 5);
    exp_q.push_back(8);
    send(1); send(1); send(1);
    do_ack();

    // Pending slot and overrun
    exp_q.push_back(20);
    send(2); send(4); send(6); send(8);
    send(10);
    check("pend_busy", 32'(busy), 1);
    check("pend_overrun", 32'(overrun), 0);
    check("pend_rv", 32'(result_valid), 1);
    send(12);
    check("ovr_overrun", 32'(overrun), 1);
    check("ovr_rv", 32'(result_valid), 1);
    exp_q.push_back(13);
    do_ack();
    check("drain_cnt", 32'(dut.cnt_q), 1);
    check("drain_acc", 32'(dut.acc_q), 10);
    check("drain_busy", 32'(busy), 1);
    send(1); send(1); send(1);
    do_ack();
    check("ovr_sticky", 32'(overrun), 1);

    // Clear mid-set
    send(4); send(6);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_cnt", 32'(dut.cnt_q), 0);
    check("clr_acc", 32'(dut.acc_q), 0);
    check("clr_overrun", 32'(overrun), 0);
    check("clr_busy", 32'(busy), 0);
    exp_q.push_back(4);
    send(1); send(1); send(1); send(1);
    do_ack();

    // Async reset mid-set
    send(5); send(5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mid_busy", 32'(busy), 0);
    check("arst_mid_cnt", 32'(dut.cnt_q), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset in DONE, released with prod_ready already high
    exp_q.push_back(4);
    send(1); send(1); send(1); send(1);
    check("arst_done_pre_rv", 32'(result_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_done_rv", 32'(result_valid), 0);
    check("arst_done_result", 32'(result), 0);
    check("arst_done_busy", 32'(busy), 0);
    product    = 8'd7;
    prod_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_hold_cnt", 32'(dut.cnt_q), 0);
    check("arst_hold_busy", 32'(busy), 0);
    prod_ready = 1'b0;
    exp_q.push_back(10);
    send(7); send(1); send(1); send(1);
    do_ack();

    repeat (2) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
